fnd_scan_decoder: RTL and testbench
===================================

// Module: fnd_scan_decoder
// PURPOSE
//  Receive-side counterpart of the 4-digit FND scan driver. Samples the multiplexed
//  fnd_digit/fnd_data lines and decodes each digit's segment pattern back to BCD.
//  Assembles complete 4-digit frames and flags bad patterns or a stalled scan.
//  Used as a board-level self-check and bench monitor for the stopwatch/watch display.
// PARAMETERS
//  STABLE_CYC   4          cycles select+data must hold unchanged before a digit is captured
//  TIMEOUT_CYC  1_000_000  cycles with no accepted digit before scan_stall asserts
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  reset        in   1   asynchronous, active-low reset
//  fnd_digit    in   4   digit select, active-low one-hot (bit0 = rightmost digit)
//  fnd_data     in   8   segments, active-low; [7]=dp, [6:0]=gfedcba
//  err_clr      in   1   clears seg_err (level, sampled each cycle)
//  bcd_frame    out  16  {d3,d2,d1,d0} decoded digits of last complete frame
//  dp_frame     out  4   decimal-point state per digit, 1 = lit
//  frame_valid  out  1   one-cycle pulse when bcd_frame/dp_frame update
//  frame_cnt    out  8   completed frames, wraps 255->0
//  seg_err      out  1   sticky: an unrecognised pattern was captured
//  scan_stall   out  1   no digit accepted for TIMEOUT_CYC cycles
// BEHAVIOUR
//  Reset: bcd_frame=16'hFFFF, dp_frame=0, frame_valid=0, frame_cnt=0, seg_err=0,
//   scan_stall=0, FSM=WAIT_SEL, staging regs and seen mask cleared.
//  Decode ([6:0] only): C0->0 F9->1 A4->2 B0->3 99->4 92->5 82->6 F8->7 80->8 90->9,
//   7F (blank)->4'hF, any other->4'hE and raises seg_err. dp = ~fnd_data[7].
//  FSM:
//   WAIT_SEL: fnd_digit not exactly one bit low -> stay; else -> SETTLE, stab_cnt=1.
//   SETTLE: {fnd_digit,fnd_data} equal to previous cycle -> stab_cnt++; any change ->
//    reload stab_cnt=1 (or WAIT_SEL if select no longer one-hot-low).
//    stab_cnt==STABLE_CYC -> capture into staging[idx], set seen[idx], -> HELD.
//   HELD: no re-capture; any change of fnd_digit -> WAIT_SEL/SETTLE as above.
//    fnd_data-only change while select held -> SETTLE (re-capture allowed).
//  Re-capture of an already-seen digit overwrites staging, mask unchanged.
//  Frame: cycle after seen==4'hF -> publish staging to bcd_frame/dp_frame, pulse
//   frame_valid, frame_cnt++, clear seen. Capture latency: STABLE_CYC cycles from
//   last change; publish latency: +1 cycle after 4th distinct digit captured.
//  seg_err: set on capture of 4'hE; err_clr clears; set and clear same cycle -> set wins.
//  scan_stall: idle counter resets on every capture; saturates at TIMEOUT_CYC and
//   asserts; deasserts on the next capture. Counter width $clog2(TIMEOUT_CYC+1).
//  Reset asserted mid-frame: staging and partial seen mask discarded, no pulse.
// STRUCTURE
//  fnd_pkg: segment code constants (SEG_0..SEG_9, SEG_BLANK), BCD_BLANK=4'hF,
//   BCD_BAD=4'hE, FSM state encodings WAIT_SEL/SETTLE/HELD.
//  Sub-module fnd_seg2bcd: combinational 7-bit pattern -> {bad, bcd[3:0]}.
//  Top holds FSM, stability/idle counters, staging regs, frame publish logic.
// TESTING
//  1) Scan d0..d3 = 90,C0,82,F9, 100 cycles each -> one frame_valid, bcd_frame=16'h1609.
//  2) fnd_data[7]=0 on d2 only during scan -> dp_frame=4'b0100, digits unaffected.
//  3) d1 held only STABLE_CYC-1 cycles, then ignored -> no frame_valid until d1 rescanned.
//  4) d3 pattern 8'hFF&~0x01 (=FE) -> bcd_frame[15:12]=4'hE, seg_err=1; err_clr -> 0.
//  5) fnd_digit=4'b1111 for TIMEOUT_CYC (param 50 in bench) -> scan_stall=1; next capture -> 0.
//  6) reset low after 3 digits captured -> all outputs at reset values; new scan -> first
//     frame_valid only after all 4 digits, frame_cnt=1. Run 256 frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/fnd_scan_decoder_pkg.sv
// Shared constants for the FND scan decoder: active-low segment codes, BCD markers,
// FSM state encoding and small select-line helpers.
package fnd_scan_decoder_pkg;

  // Segment codes on [6:0] (gfedcba, active-low); the decimal point is handled separately.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_BAD   = 4'hE;

  typedef enum logic [1:0] {
    WAIT_SEL = 2'd0,
    SETTLE   = 2'd1,
    HELD     = 2'd2
  } state_t;

  // True when exactly one of the four active-low select lines is driven low.
  function automatic logic isOneLow(input logic [3:0] sel);
    logic [3:0] act;
    act = ~sel;
    return (act != 4'h0) && ((act & (act - 4'h1)) == 4'h0);
  endfunction

  function automatic logic [1:0] lowIndex(input logic [3:0] sel);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!sel[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fnd_scan_decoder_if.sv
// Bundle of the sampled FND scan lines and the decoded frame outputs.
interface fnd_scan_decoder_if;
  logic [3:0]  fnd_digit;
  logic [7:0]  fnd_data;
  logic        err_clr;
  logic [15:0] bcd_frame;
  logic [3:0]  dp_frame;
  logic        frame_valid;
  logic [7:0]  frame_cnt;
  logic        seg_err;
  logic        scan_stall;

  modport master (
    output fnd_digit, fnd_data, err_clr,
    input  bcd_frame, dp_frame, frame_valid, frame_cnt, seg_err, scan_stall
  );

  modport slave (
    input  fnd_digit, fnd_data, err_clr,
    output bcd_frame, dp_frame, frame_valid, frame_cnt, seg_err, scan_stall
  );
endinterface

// File: rtl/fnd_scan_decoder_seg2bcd.sv
// Combinational decode of one 7-segment pattern back to BCD, flagging unknown patterns.
module fnd_scan_decoder_seg2bcd
  import fnd_scan_decoder_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_bad,
  output logic [3:0] o_bcd
);

  always_comb begin
    o_bad = 1'b0;
    o_bcd = BCD_BAD;
    case (i_seg)
      SEG_0:     o_bcd = 4'd0;
      SEG_1:     o_bcd = 4'd1;
      SEG_2:     o_bcd = 4'd2;
      SEG_3:     o_bcd = 4'd3;
      SEG_4:     o_bcd = 4'd4;
      SEG_5:     o_bcd = 4'd5;
      SEG_6:     o_bcd = 4'd6;
      SEG_7:     o_bcd = 4'd7;
      SEG_8:     o_bcd = 4'd8;
      SEG_9:     o_bcd = 4'd9;
      SEG_BLANK: o_bcd = BCD_BLANK;
      default: begin
        o_bcd = BCD_BAD;
        o_bad = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Receive side of the 4-digit FND scan: waits for each digit to settle, captures it,
// and publishes a frame once all four digit positions have been seen.
module fnd_scan_decoder
  import fnd_scan_decoder_pkg::*;
#(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                clk,
  input  logic                reset,
  fnd_scan_decoder_if.slave   fnd
);

  localparam int STAB_W = $clog2(STABLE_CYC + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  state_t              r_state;
  state_t              w_stateNext;
  logic [STAB_W-1:0]   r_stabCnt;
  logic [STAB_W-1:0]   w_stabNext;
  logic [3:0]          r_prevDigit;
  logic [7:0]          r_prevData;
  logic [IDLE_W-1:0]   r_idleCnt;

  logic [3:0]          r_seen;
  logic [3:0]          w_seenNext;
  logic [15:0]         r_stageBcd;
  logic [3:0]          r_stageDp;

  logic [15:0]         r_bcdFrame;
  logic [3:0]          r_dpFrame;
  logic                r_frameValid;
  logic [7:0]          r_frameCnt;
  logic                r_segErr;

  logic                w_selOk;
  logic [1:0]          w_idx;
  logic                w_digitChg;
  logic                w_dataChg;
  logic                w_capture;
  logic                w_publish;
  logic                w_bad;
  logic [3:0]          w_bcd;

  fnd_scan_decoder_seg2bcd u_seg2bcd (
    .i_seg (fnd.fnd_data[6:0]),
    .o_bad (w_bad),
    .o_bcd (w_bcd)
  );

  assign w_selOk    = isOneLow(fnd.fnd_digit);
  assign w_idx      = lowIndex(fnd.fnd_digit);
  assign w_digitChg = (fnd.fnd_digit != r_prevDigit);
  assign w_dataChg  = (fnd.fnd_data != r_prevData);
  assign w_publish  = (r_seen == 4'hF);

  // The stability count includes the cycle the value first appeared, so a capture
  // happens on the STABLE_CYC-th consecutive sample of an unchanged select+data.
  always_comb begin
    w_stateNext = r_state;
    w_stabNext  = r_stabCnt;
    w_capture   = 1'b0;
    case (r_state)
      WAIT_SEL: begin
        if (w_selOk) begin
          w_stateNext = SETTLE;
          w_stabNext  = STAB_W'(1);
        end
      end
      SETTLE: begin
        if (!w_selOk) begin
          w_stateNext = WAIT_SEL;
        end else if (w_digitChg || w_dataChg) begin
          w_stabNext = STAB_W'(1);
        end else if (r_stabCnt >= STAB_W'(STABLE_CYC - 1)) begin
          w_capture   = 1'b1;
          w_stateNext = HELD;
          w_stabNext  = STAB_W'(STABLE_CYC);
        end else begin
          w_stabNext = r_stabCnt + STAB_W'(1);
        end
      end
      HELD: begin
        if (w_digitChg) begin
          if (w_selOk) begin
            w_stateNext = SETTLE;
            w_stabNext  = STAB_W'(1);
          end else begin
            w_stateNext = WAIT_SEL;
          end
        end else if (w_dataChg) begin
          w_stateNext = SETTLE;
          w_stabNext  = STAB_W'(1);
        end
      end
      default: begin
        w_stateNext = WAIT_SEL;
        w_stabNext  = STAB_W'(1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= WAIT_SEL;
      r_stabCnt   <= '0;
      r_prevDigit <= 4'hF;
      r_prevData  <= 8'hFF;
    end else begin
      r_state     <= w_stateNext;
      r_stabCnt   <= w_stabNext;
      r_prevDigit <= fnd.fnd_digit;
      r_prevData  <= fnd.fnd_data;
    end
  end

  // Publishing clears the mask; a capture in the same cycle starts the next frame.
  always_comb begin
    w_seenNext = w_publish ? 4'h0 : r_seen;
    if (w_capture) w_seenNext[w_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seen     <= 4'h0;
      r_stageBcd <= 16'h0000;
      r_stageDp  <= 4'h0;
    end else begin
      r_seen <= w_seenNext;
      if (w_capture) begin
        r_stageBcd[{w_idx, 2'b00} +: 4] <= w_bcd;
        r_stageDp[w_idx]                <= ~fnd.fnd_data[7];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bcdFrame   <= 16'hFFFF;
      r_dpFrame    <= 4'h0;
      r_frameValid <= 1'b0;
      r_frameCnt   <= 8'h00;
    end else begin
      r_frameValid <= w_publish;
      if (w_publish) begin
        r_bcdFrame <= r_stageBcd;
        r_dpFrame  <= r_stageDp;
        r_frameCnt <= r_frameCnt + 8'h01;
      end
    end
  end

  // A bad capture outranks a simultaneous clear so no error can slip through unseen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_segErr <= 1'b0;
    end else if (w_capture && w_bad) begin
      r_segErr <= 1'b1;
    end else if (fnd.err_clr) begin
      r_segErr <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idleCnt <= '0;
    end else if (w_capture) begin
      r_idleCnt <= '0;
    end else if (r_idleCnt != IDLE_W'(TIMEOUT_CYC)) begin
      r_idleCnt <= r_idleCnt + IDLE_W'(1);
    end
  end

  assign fnd.bcd_frame   = r_bcdFrame;
  assign fnd.dp_frame    = r_dpFrame;
  assign fnd.frame_valid = r_frameValid;
  assign fnd.frame_cnt   = r_frameCnt;
  assign fnd.seg_err     = r_segErr;
  assign fnd.scan_stall  = (r_idleCnt == IDLE_W'(TIMEOUT_CYC));

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Directed bench for fnd_scan_decoder: table of full-frame scans plus hand-written
// sequences for short holds, error stickiness, stall timeout, reset and counter wrap.
module tb_fnd_scan_decoder;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 50;

  typedef struct {
    logic [3:0][7:0] seg;
    logic [15:0]     bcd;
    logic [3:0]      dp;
    int              hold;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  int   base;
  vec_t vecs [4];

  fnd_scan_decoder_if fnd ();

  fnd_scan_decoder #(
    .STABLE_CYC  (STABLE),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fnd   (fnd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fnd.frame_valid === 1'b1) pulses++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Caller sits just after a rising edge; inputs change there and hold for 'hold' edges.
  task automatic applyStimulus(input int digit, input logic [7:0] data, input int hold);
    logic [3:0] sel;
    sel = 4'b0001 << digit;
    fnd.fnd_digit = ~sel;
    fnd.fnd_data  = data;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic scanFrame(input logic [3:0][7:0] seg, input int hold);
    for (int d = 0; d < 4; d++) applyStimulus(d, seg[d], hold);
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    @(negedge clk);
    checkOutput({tag, "_bcd"},   32'(fnd.bcd_frame),   32'hFFFF);
    checkOutput({tag, "_dp"},    32'(fnd.dp_frame),    32'h0);
    checkOutput({tag, "_valid"}, 32'(fnd.frame_valid), 32'h0);
    checkOutput({tag, "_cnt"},   32'(fnd.frame_cnt),   32'h0);
    checkOutput({tag, "_err"},   32'(fnd.seg_err),     32'h0);
    checkOutput({tag, "_stall"}, 32'(fnd.scan_stall),  32'h0);
  endtask

  initial begin
    vecs[0] = '{seg: {8'hF9, 8'h82, 8'hC0, 8'h90}, bcd: 16'h1609, dp: 4'b0000, hold: 100};
    vecs[1] = '{seg: {8'hB0, 8'h24, 8'hF9, 8'hC0}, bcd: 16'h3210, dp: 4'b0100, hold: 10};
    vecs[2] = '{seg: {8'h80, 8'hF8, 8'h92, 8'h99}, bcd: 16'h8754, dp: 4'b0000, hold: 10};
    vecs[3] = '{seg: {8'hFF, 8'h40, 8'h10, 8'hFF}, bcd: 16'hF09F, dp: 4'b0110, hold: 10};

    fnd.fnd_digit = 4'hF;
    fnd.fnd_data  = 8'hFF;
    fnd.err_clr   = 1'b0;
    reset         = 1'b0;
    waitEdges(3);
    checkResetValues("reset");
    reset = 1'b1;
    waitEdges(2);

    $display("[TB] table-driven frame scans");
    for (int i = 0; i < 4; i++) begin
      base = pulses;
      scanFrame(vecs[i].seg, vecs[i].hold);
      waitEdges(2);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_pulses", i), 32'(pulses - base), 32'd1);
      checkOutput($sformatf("vec%0d_bcd", i),    32'(fnd.bcd_frame), 32'(vecs[i].bcd));
      checkOutput($sformatf("vec%0d_dp", i),     32'(fnd.dp_frame),  32'(vecs[i].dp));
      checkOutput($sformatf("vec%0d_cnt", i),    32'(fnd.frame_cnt), 32'(i + 1));
      checkOutput($sformatf("vec%0d_err", i),    32'(fnd.seg_err),   32'd0);
      @(posedge clk);
      #1;
    end

    $display("[TB] digit held one cycle short of capture");
    base = pulses;
    applyStimulus(0, 8'hC0, 10);
    applyStimulus(1, 8'hF9, STABLE - 1);
    applyStimulus(2, 8'hA4, 10);
    applyStimulus(3, 8'hB0, 10);
    @(negedge clk);
    checkOutput("short_hold_no_frame", 32'(pulses - base), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(1, 8'hF9, STABLE);
    waitEdges(2);
    @(negedge clk);
    checkOutput("rescan_pulses", 32'(pulses - base), 32'd1);
    checkOutput("rescan_bcd",    32'(fnd.bcd_frame), 32'h3210);
    checkOutput("rescan_dp",     32'(fnd.dp_frame),  32'h0);
    checkOutput("rescan_cnt",    32'(fnd.frame_cnt), 32'd5);
    @(posedge clk);
    #1;

    $display("[TB] bad segment pattern and error clear");
    base = pulses;
    applyStimulus(0, 8'hC0, 10);
    applyStimulus(1, 8'hC0, 10);
    applyStimulus(2, 8'hC0, 10);
    fnd.err_clr = 1'b1;
    applyStimulus(3, 8'hFE, STABLE);
    fnd.err_clr = 1'b0;
    @(negedge clk);
    checkOutput("err_set_wins", 32'(fnd.seg_err), 32'd1);
    @(posedge clk);
    #1;
    waitEdges(2);
    @(negedge clk);
    checkOutput("bad_pulses",  32'(pulses - base), 32'd1);
    checkOutput("bad_bcd",     32'(fnd.bcd_frame), 32'hE000);
    checkOutput("err_sticky",  32'(fnd.seg_err),   32'd1);
    @(posedge clk);
    #1;
    fnd.err_clr = 1'b1;
    waitEdges(1);
    fnd.err_clr = 1'b0;
    @(negedge clk);
    checkOutput("err_cleared", 32'(fnd.seg_err), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] scan stall timeout");
    applyStimulus(0, 8'hC0, STABLE);
    fnd.fnd_digit = 4'hF;
    waitEdges(TIMEOUT - 1);
    @(negedge clk);
    checkOutput("stall_before_timeout", 32'(fnd.scan_stall), 32'd0);
    waitEdges(1);
    @(negedge clk);
    checkOutput("stall_at_timeout", 32'(fnd.scan_stall), 32'd1);
    waitEdges(20);
    @(negedge clk);
    checkOutput("stall_saturated", 32'(fnd.scan_stall), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(1, 8'hF9, STABLE - 1);
    @(negedge clk);
    checkOutput("stall_before_capture", 32'(fnd.scan_stall), 32'd1);
    waitEdges(1);
    @(negedge clk);
    checkOutput("stall_released", 32'(fnd.scan_stall), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] reset mid-frame");
    applyStimulus(0, 8'h90, 10);
    applyStimulus(1, 8'hF8, 10);
    applyStimulus(2, 8'h80, 10);
    reset = 1'b0;
    fnd.fnd_digit = 4'hF;
    fnd.fnd_data  = 8'hFF;
    waitEdges(2);
    checkResetValues("midreset");
    reset = 1'b1;
    waitEdges(2);
    base = pulses;
    applyStimulus(3, 8'h99, 10);
    applyStimulus(0, 8'h90, 10);
    applyStimulus(1, 8'hF8, 10);
    @(negedge clk);
    checkOutput("partial_no_frame", 32'(pulses - base), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(2, 8'h80, 10);
    @(negedge clk);
    checkOutput("post_reset_pulses", 32'(pulses - base), 32'd1);
    checkOutput("post_reset_cnt",    32'(fnd.frame_cnt), 32'd1);
    checkOutput("post_reset_bcd",    32'(fnd.bcd_frame), 32'h4879);
    @(posedge clk);
    #1;

    $display("[TB] frame counter wrap");
    for (int k = 0; k < 255; k++) scanFrame(vecs[k % 4].seg, 5);
    waitEdges(3);
    @(negedge clk);
    checkOutput("wrap_pulses", 32'(pulses - base), 32'd256);
    checkOutput("wrap_cnt",    32'(fnd.frame_cnt), 32'd0);
    checkOutput("wrap_bcd",    32'(fnd.bcd_frame), 32'(vecs[254 % 4].bcd));
    checkOutput("wrap_dp",     32'(fnd.dp_frame),  32'(vecs[254 % 4].dp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
